// File: rtl/wb_stage_param.sv
// Writeback stage: registers the MEM->WB payload, drives the register-file write
// port, and exposes bypass, retire-count and debug views of the held instruction.
module wb_stage_param #(
  parameter int PC_W          = 32,
  parameter int REG_AW        = 5,
  parameter int DATA_W        = 32,
  parameter int CNT_W         = 32,
  parameter int ZERO_SUPPRESS = 1,
  localparam int WB_W         = PC_W + REG_AW + DATA_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WB_W-1:0]       to_WB_data,
  input  logic                  MEM_to_WB_valid,
  output logic                  WB_allow_in,
  input  logic                  wb_stall,
  input  logic                  wb_flush,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  WB_dest_valid,
  output logic [REG_AW-1:0]     WB_dest,
  output logic [DATA_W-1:0]     WB_result,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [PC_W-1:0]       debug_wb_pc,
  output logic [DATA_W/8-1:0]   debug_wb_rf_we,
  output logic [REG_AW-1:0]     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]     debug_wb_rf_wdata
);

  // Handshake: a payload moves MEM->WB on an edge where MEM_to_WB_valid and
  // WB_allow_in are both high (and no flush); WB_allow_in depends only on WB
  // state and wb_stall, never on MEM_to_WB_valid or the payload.
  logic              wb_valid_q, wb_valid_d;
  logic [WB_W-1:0]   payload_q, payload_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic              wb_ready_go;
  logic              accept;
  logic              retire_go;
  logic              live;
  logic              dest_is_zero;

  logic [PC_W-1:0]   wb_pc;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_result;
  logic              wb_gr_we;

  assign {wb_pc, wb_dest, wb_result, wb_gr_we} = payload_q;

  assign wb_ready_go  = ~wb_stall;
  assign WB_allow_in  = ~wb_valid_q | wb_ready_go;
  assign accept       = WB_allow_in & MEM_to_WB_valid & ~wb_flush;
  assign retire_go    = wb_valid_q & wb_ready_go & ~wb_flush;
  assign dest_is_zero = (wb_dest == '0);
  assign live         = wb_valid_q & wb_gr_we & ~((ZERO_SUPPRESS != 0) & dest_is_zero);

  always_comb begin
    payload_d    = payload_q;
    wb_valid_d   = wb_valid_q;
    retire_cnt_d = retire_cnt_q;
    if (accept) begin
      payload_d = to_WB_data;
    end
    if (wb_flush) begin
      wb_valid_d = 1'b0;
    end else if (WB_allow_in) begin
      wb_valid_d = MEM_to_WB_valid;
    end
    if (retire_go) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q   <= 1'b0;
      payload_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      payload_q    <= payload_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // A stalled instruction writes only once, on the cycle the stall drops.
  assign rf_we         = live & wb_ready_go & ~wb_flush;
  assign rf_waddr      = wb_dest;
  assign rf_wdata      = wb_result;

  assign WB_dest_valid = live & ~wb_flush;
  assign WB_dest       = wb_dest;
  assign WB_result     = wb_result;

  assign retire_cnt    = retire_cnt_q;

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {(DATA_W/8){rf_we}};
  assign debug_wb_rf_wnum  = wb_dest;
  assign debug_wb_rf_wdata = wb_result;

endmodule

// File: tb/tb_wb_stage_param.sv
// Bench for wb_stage_param: directed scenarios plus random traffic, checked
// against an instruction-level model of the WB slot and an expected write queue.
module tb_wb_stage_param;

  localparam int PC_W   = 32;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int WB_W   = PC_W + REG_AW + DATA_W + 1;
  localparam int WR_W   = REG_AW + DATA_W;

  logic                clk;
  logic                reset;
  logic [WB_W-1:0]     to_WB_data;
  logic                MEM_to_WB_valid;
  logic                WB_allow_in;
  logic                wb_stall;
  logic                wb_flush;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                WB_dest_valid;
  logic [REG_AW-1:0]   WB_dest;
  logic [DATA_W-1:0]   WB_result;
  logic [CNT_W-1:0]    retire_cnt;
  logic [PC_W-1:0]     debug_wb_pc;
  logic [DATA_W/8-1:0] debug_wb_rf_we;
  logic [REG_AW-1:0]   debug_wb_rf_wnum;
  logic [DATA_W-1:0]   debug_wb_rf_wdata;

  wb_stage_param #(
    .PC_W(PC_W), .REG_AW(REG_AW), .DATA_W(DATA_W), .CNT_W(CNT_W), .ZERO_SUPPRESS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .to_WB_data(to_WB_data), .MEM_to_WB_valid(MEM_to_WB_valid),
    .WB_allow_in(WB_allow_in), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .WB_dest_valid(WB_dest_valid), .WB_dest(WB_dest), .WB_result(WB_result),
    .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    bit [31:0]   pc;
    bit [4:0]    dest;
    bit [31:0]   result;
    bit          gr_we;
  } slot_t;

  slot_t m;
  int    m_retired;

  logic [WR_W-1:0] exp_q[$];
  logic [WR_W-1:0] got_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB_W-1:0] mk(input logic [31:0] pc, input logic [4:0] dest,
                                         input logic [31:0] res, input logic we);
    return {pc, dest, res, we};
  endfunction

  task automatic model_clear();
    m.valid = 0; m.pc = 0; m.dest = 0; m.result = 0; m.gr_we = 0;
    m_retired = 0;
  endtask

  // Expected outputs for the instruction currently in WB, given this cycle's stall/flush.
  task automatic check_outputs(input logic st, input logic fl);
    bit writes_reg;
    bit exp_we;
    writes_reg = m.valid && m.gr_we && (m.dest != 0);
    exp_we     = writes_reg && !st && !fl;
    chk("allow_in",    64'(WB_allow_in),       64'(!m.valid || !st));
    chk("rf_we",       64'(rf_we),             64'(exp_we));
    chk("rf_waddr",    64'(rf_waddr),          64'(m.dest));
    chk("rf_wdata",    64'(rf_wdata),          64'(m.result));
    chk("dest_valid",  64'(WB_dest_valid),     64'(writes_reg && !fl));
    chk("wb_dest",     64'(WB_dest),           64'(m.dest));
    chk("wb_result",   64'(WB_result),         64'(m.result));
    chk("retire_cnt",  64'(retire_cnt),        64'(m_retired % (1 << CNT_W)));
    chk("dbg_pc",      64'(debug_wb_pc),       64'(m.pc));
    chk("dbg_we",      64'(debug_wb_rf_we),    exp_we ? 64'hf : 64'h0);
    chk("dbg_wnum",    64'(debug_wb_rf_wnum),  64'(m.dest));
    chk("dbg_wdata",   64'(debug_wb_rf_wdata), 64'(m.result));
    if (exp_we) exp_q.push_back({m.dest, m.result});
    if (rf_we === 1'b1) got_q.push_back({rf_waddr, rf_wdata});
  endtask

  // Slot semantics: an instruction leaves when not stalled; flush kills both the
  // resident and any arriving instruction; a new one enters whenever the slot frees.
  task automatic model_step(input logic mv, input logic [WB_W-1:0] data,
                            input logic st, input logic fl);
    bit leaves;
    bit slot_free;
    leaves    = m.valid && !st;
    slot_free = !m.valid || !st;
    if (fl) begin
      m.valid = 0;
    end else begin
      if (leaves) m_retired++;
      if (slot_free) begin
        m.valid = mv;
        if (mv) begin
          m.pc     = data[WB_W-1 -: 32];
          m.dest   = data[DATA_W+REG_AW : DATA_W+1];
          m.result = data[DATA_W:1];
          m.gr_we  = data[0];
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic mv, input logic [WB_W-1:0] data,
                       input logic st, input logic fl);
    @(negedge clk);
    MEM_to_WB_valid = mv;
    to_WB_data      = data;
    wb_stall        = st;
    wb_flush        = fl;
    #1;
    check_outputs(st, fl);
    @(posedge clk);
    model_step(mv, data, st, fl);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Reset raised in the middle of the high phase, checked before any further edge.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_rf_we",      64'(rf_we),          64'h0);
    chk("rst_retire_cnt", 64'(retire_cnt),     64'h0);
    chk("rst_allow_in",   64'(WB_allow_in),    64'h1);
    chk("rst_dbg_pc",     64'(debug_wb_pc),    64'h0);
    chk("rst_dest_valid", 64'(WB_dest_valid),  64'h0);
    chk("rst_dbg_we",     64'(debug_wb_rf_we), 64'h0);
    model_clear();
    @(negedge clk);
    MEM_to_WB_valid = 1'b0;
    to_WB_data      = '0;
    wb_stall        = 1'b0;
    wb_flush        = 1'b0;
    reset           = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    MEM_to_WB_valid = 1'b0;
    to_WB_data      = '0;
    wb_stall        = 1'b0;
    wb_flush        = 1'b0;
    model_clear();
    #12;
    chk("init_rf_we",     64'(rf_we),       64'h0);
    chk("init_cnt",       64'(retire_cnt),  64'h0);
    chk("init_allow_in",  64'(WB_allow_in), 64'h1);
    chk("init_dbg_pc",    64'(debug_wb_pc), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // streaming: three back-to-back writes
    cycle(1'b1, mk(32'h1c000000, 5'd5, 32'h11, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h1c000004, 5'd6, 32'h22, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h1c000008, 5'd7, 32'h33, 1'b1), 1'b0, 1'b0);
    idle();
    @(negedge clk); #1;
    chk("stream_cnt", 64'(retire_cnt), 64'd3);

    // stall: r3 <- 0xAB held for two cycles while MEM offers another payload
    cycle(1'b1, mk(32'h1c00000c, 5'd3, 32'hAB, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h1c000010, 5'd4, 32'hCD, 1'b1), 1'b1, 1'b0);
    cycle(1'b1, mk(32'h1c000010, 5'd4, 32'hCD, 1'b1), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // zero register and no-write instructions still retire
    cycle(1'b1, mk(32'h1c000020, 5'd0, 32'h55, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h1c000024, 5'd9, 32'h66, 1'b0), 1'b0, 1'b0);
    idle();

    // flush with a resident instruction and an arriving one
    cycle(1'b1, mk(32'h1c000030, 5'd10, 32'h77, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h1c000034, 5'd11, 32'h88, 1'b1), 1'b0, 1'b1);
    idle();

    // flush together with stall
    cycle(1'b1, mk(32'h1c000040, 5'd12, 32'h99, 1'b1), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    idle();

    // stall with an empty slot still accepts
    cycle(1'b1, mk(32'h1c000050, 5'd13, 32'hA5, 1'b1), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    idle();

    // reset in the middle of a stall drops the held write
    cycle(1'b1, mk(32'h1c000060, 5'd14, 32'h5A, 1'b1), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    async_reset();
    idle();

    // counter wrap: 17 retirements with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, mk($urandom, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1))),
            1'b0, 1'b0);
    end
    idle();
    @(negedge clk); #1;
    chk("wrap_cnt", 64'(retire_cnt), 64'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(1'($urandom_range(0, 3) != 0),
            mk($urandom, d, $urandom, 1'($urandom_range(0, 3) != 0)),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0));
    end
    idle();
    idle();

    // ---------------- final report ----------------
    chk("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("write_log", 64'(got_q[i]), 64'(exp_q[i]));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
